vga_timing_gen: RTL
===================

# vga_timing_gen

Parametrised VGA raster timing generator, replacing the fixed-mode driver instantiated under `top`. Owns horizontal/vertical counters, emits pixel-coordinate requests ahead of the pins to cover a configurable pixel-source latency, and re-aligns sync, blanking and colour at the output. Also arbitrates a double-buffer swap at vertical-blank start so the physics renderer can flip framebuffers without tearing.

## Interface
- `H_ACTIVE`, 1600: visible pixels per line
- `H_FP`, 64 / `H_SYNC`, 192 / `H_BP`, 304: horizontal porch/sync widths in clocks
- `V_ACTIVE`, 1200: visible lines
- `V_FP`, 1 / `V_SYNC`, 3 / `V_BP`, 46: vertical porch/sync widths in lines
- `HSYNC_POL`, 1 / `VSYNC_POL`, 1: active level of each sync
- `COLOR_W`, 4: bits per colour channel
- `PIPE_LAT`, 2: cycles from `pix_x/pix_y` request to `pix_r/g/b` valid; must be ≥0

Ports:
- `clock_162` in 1: pixel clock
- `rst` in 1: asynchronous, active-low reset
- `pix_x` out H_W: requested column, H_W = $clog2(H_TOTAL)
- `pix_y` out V_W: requested row, V_W = $clog2(V_TOTAL)
- `pix_valid` out 1: request is in the active area
- `pix_r`, `pix_g`, `pix_b` in COLOR_W each: colour for the request issued PIPE_LAT cycles earlier
- `HSYNC`, `VSYNC` out 1: sync pins
- `RED`, `GREEN`, `BLUE` out COLOR_W each: colour pins
- `frame_start` out 1: one-cycle pulse at the request for (0,0)
- `swap_req` in 1: level request to flip framebuffers
- `swap_ack` out 1: one-cycle pulse when the flip occurs
- `fb_sel` out 1: framebuffer currently scanned out

## Operation
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise.
- `h_cnt` runs 0..H_TOTAL-1 and wraps. `v_cnt` increments when `h_cnt` wraps and itself wraps at V_TOTAL-1 to 0.
- Request stage is combinational from the counters, with registered counters:
  - `pix_x`=`h_cnt`, `pix_y`=`v_cnt`
  - `pix_valid` = (h<H_ACTIVE)&&(v<V_ACTIVE)
- Raw sync:
  - hs active for h in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC)
  - vs active for v in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC), whole lines
- `pix_valid`, hs and vs pass through a PIPE_LAT-deep delay line, then a final output register. `pix_r/g/b` are sampled into that same output register.
- Pins:
  - `RED/GREEN/BLUE` = delayed valid ? `pix_*` : 0
  - `HSYNC` = hs ? HSYNC_POL : ~HSYNC_POL, likewise `VSYNC`
- `frame_start` = (h==0 && v==0), at request timing.
- Swap:
  - `swap_req` is sampled only on the cycle h==0, v==V_ACTIVE (vblank start).
  - If high on that cycle, `fb_sel` toggles on the next edge and `swap_ack` pulses for exactly one cycle, coincident with the toggle.
  - Requests outside that cycle wait. If `swap_req` is still high at the following vblank start, a second swap occurs. The requester must drop `swap_req` after `swap_ack`.
- Reset values:
  - counters 0, `pix_x`/`pix_y` 0, `pix_valid` 0
  - delay line cleared to inactive
  - `HSYNC`=~HSYNC_POL, `VSYNC`=~VSYNC_POL
  - colours 0, `frame_start` 0, `swap_ack` 0, `fb_sel` 0
- Reset asserted mid-frame: all state returns to reset values immediately, with no partial swap. `fb_sel` returns to 0.

## Timing
- First edge after `rst` deasserts: counters at (0,0), so `pix_valid`=1 and `frame_start`=1.
- Request-to-pin latency is PIPE_LAT+1 cycles for colour, HSYNC, VSYNC and blanking, all mutually aligned.
- HSYNC period is H_TOTAL cycles and its width H_SYNC. VSYNC width is V_SYNC·H_TOTAL cycles.
- `frame_start` period is H_TOTAL·V_TOTAL cycles.
- `swap_ack` comes 1 cycle after the sampling point. `fb_sel` changes only within vblank.

## Structure
- `vga_pkg`: default timing localparams (1600x1200@60 at 162 MHz) and a `vga_timing_t` struct of the eight timing fields for future mode tables.
- Sub-module `vga_delay_line` (parametrised WIDTH, DEPTH; DEPTH=0 is a wire; async active-low clear). Carries {valid, hs, vs}.

## Test plan
Small test config: H 8/2/3/3 (total 16), V 4/1/2/1 (total 8), PIPE_LAT=2, polarity 0.
- Reset and release:
  - while `rst`=0: HSYNC=VSYNC=1, colours 0, `fb_sel`=0
  - first edge after release: `pix_x`=0, `pix_y`=0, `pix_valid`=1, `frame_start`=1
- Horizontal:
  - HSYNC low for 3 cycles
  - first low pin cycle is 3 cycles after the `pix_x`=10 request
  - period is 16 cycles
- Vertical: VSYNC low for exactly 32 cycles starting 3 cycles after request (0,5); `frame_start` every 128 cycles.
- Colour alignment: drive `pix_r` = `pix_x` delayed 2 cycles. RED shows 0..7 in order, then 0 through blanking, and stays 0 during lines 4..7.
- Swap:
  - `swap_req`=1 at (3,1): `swap_ack` pulses once, 1 cycle after (0,4); `fb_sel`=1
  - holding `swap_req` for two frames gives two acks and `fb_sel` back to 0
- Reset mid-frame at (5,2) with `fb_sel`=1: outputs return to reset values asynchronously; restart at (0,0) with `fb_sel`=0.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared timing defaults for the VGA raster generator (1600x1200@60, 162 MHz pixel clock)
// plus a mode-descriptor struct for future mode tables.
package vga_pkg;

    typedef struct packed {
        int unsigned h_active;
        int unsigned h_fp;
        int unsigned h_sync;
        int unsigned h_bp;
        int unsigned v_active;
        int unsigned v_fp;
        int unsigned v_sync;
        int unsigned v_bp;
    } vga_timing_t;

    localparam int unsigned DefHActive = 1600;
    localparam int unsigned DefHFp     = 64;
    localparam int unsigned DefHSync   = 192;
    localparam int unsigned DefHBp     = 304;
    localparam int unsigned DefVActive = 1200;
    localparam int unsigned DefVFp     = 1;
    localparam int unsigned DefVSync   = 3;
    localparam int unsigned DefVBp     = 46;

    localparam vga_timing_t DefTiming = '{
        h_active: DefHActive, h_fp: DefHFp, h_sync: DefHSync, h_bp: DefHBp,
        v_active: DefVActive, v_fp: DefVFp, v_sync: DefVSync, v_bp: DefVBp
    };

    function automatic int unsigned vga_total(input int unsigned active, input int unsigned fp,
                                              input int unsigned sync, input int unsigned bp);
        return active + fp + sync + bp;
    endfunction

endpackage

// File: rtl/vga_delay_line.sv
// Fixed-depth shift register with asynchronous active-low clear; DEPTH=0 degenerates to a wire.
module vga_delay_line #(
    parameter int unsigned WIDTH = 1,
    parameter int unsigned DEPTH = 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    if (DEPTH == 0) begin : g_wire
        assign q_o = d_i;
    end else begin : g_pipe
        logic [WIDTH-1:0] stage_q [DEPTH];
        logic [WIDTH-1:0] stage_d [DEPTH];

        always_comb begin
            stage_d[0] = d_i;
            for (int i = 1; i < DEPTH; i++) begin
                stage_d[i] = stage_q[i-1];
            end
        end

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                for (int i = 0; i < DEPTH; i++) begin
                    stage_q[i] <= '0;
                end
            end else begin
                stage_q <= stage_d;
            end
        end

        assign q_o = stage_q[DEPTH-1];
    end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: counters issue pixel requests PIPE_LAT cycles ahead of the pins,
// sync/blank are delayed to re-align with returned colour, and framebuffer swaps land in vblank.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int unsigned H_ACTIVE  = DefHActive,
    parameter int unsigned H_FP      = DefHFp,
    parameter int unsigned H_SYNC    = DefHSync,
    parameter int unsigned H_BP      = DefHBp,
    parameter int unsigned V_ACTIVE  = DefVActive,
    parameter int unsigned V_FP      = DefVFp,
    parameter int unsigned V_SYNC    = DefVSync,
    parameter int unsigned V_BP      = DefVBp,
    parameter bit          HSYNC_POL = 1'b1,
    parameter bit          VSYNC_POL = 1'b1,
    parameter int unsigned COLOR_W   = 4,
    parameter int unsigned PIPE_LAT  = 2,
    localparam int unsigned H_TOTAL  = vga_total(H_ACTIVE, H_FP, H_SYNC, H_BP),
    localparam int unsigned V_TOTAL  = vga_total(V_ACTIVE, V_FP, V_SYNC, V_BP),
    localparam int unsigned H_W      = $clog2(H_TOTAL),
    localparam int unsigned V_W      = $clog2(V_TOTAL)
) (
    input  logic               clock_162,
    input  logic               rst,
    output logic [H_W-1:0]     pix_x,
    output logic [V_W-1:0]     pix_y,
    output logic               pix_valid,
    input  logic [COLOR_W-1:0] pix_r,
    input  logic [COLOR_W-1:0] pix_g,
    input  logic [COLOR_W-1:0] pix_b,
    output logic               HSYNC,
    output logic               VSYNC,
    output logic [COLOR_W-1:0] RED,
    output logic [COLOR_W-1:0] GREEN,
    output logic [COLOR_W-1:0] BLUE,
    output logic               frame_start,
    input  logic               swap_req,
    output logic               swap_ack,
    output logic               fb_sel
);

    localparam int unsigned HSyncStart = H_ACTIVE + H_FP;
    localparam int unsigned HSyncEnd   = H_ACTIVE + H_FP + H_SYNC;
    localparam int unsigned VSyncStart = V_ACTIVE + V_FP;
    localparam int unsigned VSyncEnd   = V_ACTIVE + V_FP + V_SYNC;

    // run_q holds the counters at (0,0) through reset so requests only appear after release
    logic               run_q, run_d;
    logic [H_W-1:0]     h_cnt_q, h_cnt_d;
    logic [V_W-1:0]     v_cnt_q, v_cnt_d;
    logic               fb_sel_q, fb_sel_d;
    logic               swap_ack_q, swap_ack_d;
    logic               hsync_q, hsync_d;
    logic               vsync_q, vsync_d;
    logic [COLOR_W-1:0] red_q, red_d, green_q, green_d, blue_q, blue_d;

    int unsigned h_pos, v_pos;
    logic        act_raw, hs_raw, vs_raw;
    logic        dly_valid, dly_hs, dly_vs;

    assign h_pos = 32'(h_cnt_q);
    assign v_pos = 32'(v_cnt_q);

    always_comb begin
        act_raw = run_q && (h_pos < H_ACTIVE) && (v_pos < V_ACTIVE);
        hs_raw  = run_q && (h_pos >= HSyncStart) && (h_pos < HSyncEnd);
        vs_raw  = run_q && (v_pos >= VSyncStart) && (v_pos < VSyncEnd);

        run_d   = 1'b1;
        h_cnt_d = h_cnt_q;
        v_cnt_d = v_cnt_q;
        if (run_q) begin
            if (h_pos == H_TOTAL - 1) begin
                h_cnt_d = '0;
                v_cnt_d = (v_pos == V_TOTAL - 1) ? '0 : v_cnt_q + V_W'(1);
            end else begin
                h_cnt_d = h_cnt_q + H_W'(1);
            end
        end

        swap_ack_d = run_q && (h_pos == 0) && (v_pos == V_ACTIVE) && swap_req;
        fb_sel_d   = fb_sel_q ^ swap_ack_d;

        hsync_d = dly_hs ? HSYNC_POL : ~HSYNC_POL;
        vsync_d = dly_vs ? VSYNC_POL : ~VSYNC_POL;
        red_d   = dly_valid ? pix_r : '0;
        green_d = dly_valid ? pix_g : '0;
        blue_d  = dly_valid ? pix_b : '0;
    end

    vga_delay_line #(
        .WIDTH (3),
        .DEPTH (PIPE_LAT)
    ) u_delay_line (
        .clk_i  (clock_162),
        .rst_ni (rst),
        .d_i    ({act_raw, hs_raw, vs_raw}),
        .q_o    ({dly_valid, dly_hs, dly_vs})
    );

    always_ff @(posedge clock_162 or negedge rst) begin
        if (!rst) begin
            run_q      <= 1'b0;
            h_cnt_q    <= '0;
            v_cnt_q    <= '0;
            fb_sel_q   <= 1'b0;
            swap_ack_q <= 1'b0;
            hsync_q    <= ~HSYNC_POL;
            vsync_q    <= ~VSYNC_POL;
            red_q      <= '0;
            green_q    <= '0;
            blue_q     <= '0;
        end else begin
            run_q      <= run_d;
            h_cnt_q    <= h_cnt_d;
            v_cnt_q    <= v_cnt_d;
            fb_sel_q   <= fb_sel_d;
            swap_ack_q <= swap_ack_d;
            hsync_q    <= hsync_d;
            vsync_q    <= vsync_d;
            red_q      <= red_d;
            green_q    <= green_d;
            blue_q     <= blue_d;
        end
    end

    assign pix_x       = h_cnt_q;
    assign pix_y       = v_cnt_q;
    assign pix_valid   = act_raw;
    assign frame_start = run_q && (h_pos == 0) && (v_pos == 0);
    assign HSYNC       = hsync_q;
    assign VSYNC       = vsync_q;
    assign RED         = red_q;
    assign GREEN       = green_q;
    assign BLUE        = blue_q;
    assign swap_ack    = swap_ack_q;
    assign fb_sel      = fb_sel_q;

endmodule
